// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns and reader FSM states
package seg7_pkg;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational segment pattern to BCD lookup
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic       blank,
  output logic [3:0] bcd
);

  // Map a sampled pattern to its digit; anything unlisted is illegal
  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    bcd   = 4'd0;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - debounced seven-segment digit reader with history
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [6:0]                   leds,
  input  logic                         clear,
  output logic [3:0]                   bcd,
  output logic                         digit_valid,
  output logic                         illegal,
  output logic [4*DIGITS-1:0]          history,
  output logic [$clog2(DIGITS+1)-1:0]  count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int NW = $clog2(DIGITS + 1);
  localparam int HW = 4 * DIGITS;
  // The edge that would bring the counter to STABLE_CYCLES is the accepting edge
  localparam logic [CW-1:0] ACCEPT_AT = CW'(STABLE_CYCLES - 1);
  localparam logic [NW-1:0] COUNT_MAX = NW'(DIGITS);

  state_e         state_q, state_d;
  logic [6:0]     s_q;
  logic [6:0]     cand_q, cand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bcd_q, bcd_d;
  logic           dv_q, dv_d;
  logic           ill_q, ill_d;
  logic [HW-1:0]  hist_q, hist_d;
  logic [NW-1:0]  count_q, count_d;

  logic           dec_legal;
  logic           dec_blank;
  logic [3:0]     dec_bcd;
  logic           accept;

  // All decisions are taken on the registered sample, never on raw leds
  seg7_decode u_decode (
    .pattern (s_q),
    .legal   (dec_legal),
    .blank   (dec_blank),
    .bcd     (dec_bcd)
  );

  // Next-state: stability filter FSM plus acceptance side effects
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    dv_d    = 1'b0;
    ill_d   = 1'b0;
    hist_d  = hist_q;
    count_d = count_q;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!dec_blank) begin
          state_d = ST_FILTER;
          cand_d  = s_q;
          cnt_d   = CW'(1);
        end
      end
      ST_FILTER: begin
        if (dec_blank) begin
          state_d = ST_IDLE;
          cand_d  = SEG_BLANK;
          cnt_d   = '0;
        end else if (s_q == cand_q) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == ACCEPT_AT) begin
            state_d = ST_HOLD;
            accept  = 1'b1;
          end
        end else begin
          cand_d = s_q;
          cnt_d  = CW'(1);
        end
      end
      ST_HOLD: begin
        // Holding an accepted pattern produces no further pulses
        if (dec_blank) begin
          state_d = ST_IDLE;
          cand_d  = SEG_BLANK;
          cnt_d   = '0;
        end else if (s_q != cand_q) begin
          state_d = ST_FILTER;
          cand_d  = s_q;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cand_d  = SEG_BLANK;
        cnt_d   = '0;
      end
    endcase

    // At acceptance s equals the candidate, so the decoder output describes it
    if (accept) begin
      if (dec_legal) begin
        dv_d   = 1'b1;
        bcd_d  = dec_bcd;
        hist_d = (hist_q << 4) | HW'(dec_bcd);
        if (count_q != COUNT_MAX) begin
          count_d = count_q + NW'(1);
        end
      end else begin
        ill_d = 1'b1;
      end
    end

    // clear wins over the history/count update but leaves the pulse and bcd alone
    if (clear) begin
      hist_d  = '0;
      count_d = '0;
    end
  end

  // Single state register; reset overrides clear and every other input
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= SEG_BLANK;
      cand_q  <= SEG_BLANK;
      cnt_q   <= '0;
      bcd_q   <= 4'd0;
      dv_q    <= 1'b0;
      ill_q   <= 1'b0;
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= leds;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      dv_q    <= dv_d;
      ill_q   <= ill_d;
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  assign bcd         = bcd_q;
  assign digit_valid = dv_q;
  assign illegal     = ill_q;
  assign history     = hist_q;
  assign count       = count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - self-checking bench for seg7_reader
module tb_seg7_reader;

  localparam int SC = 4;
  localparam int ND = 4;
  localparam int HW = 4 * ND;
  localparam int NW = $clog2(ND + 1);
  localparam logic [6:0] BLANK_P = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [6:0]    leds;
  logic [3:0]    bcd;
  logic          digit_valid;
  logic          illegal;
  logic [HW-1:0] history;
  logic [NW-1:0] count;

  always #5 clk = ~clk;

  seg7_reader #(
    .STABLE_CYCLES (SC),
    .DIGITS        (ND)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .leds        (leds),
    .clear       (clear),
    .bcd         (bcd),
    .digit_valid (digit_valid),
    .illegal     (illegal),
    .history     (history),
    .count       (count)
  );

  logic [6:0] digit_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dv_n   = 0;
  int ill_n  = 0;
  int dv_cyc = 0;
  int start  = 0;

  // Reference model: a pattern is taken once per run of identical samples,
  // exactly when that run reaches SC samples.
  logic [6:0]    m_s;
  int            m_run;
  logic [3:0]    m_bcd;
  logic          m_dv;
  logic          m_ill;
  logic [HW-1:0] m_hist;
  int            m_cnt;

  function automatic int classify(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (p == digit_pat[i]) return i;
    end
    if (p == BLANK_P) return 10;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int k;
    if (!reset) begin
      m_s = BLANK_P; m_run = 0; m_bcd = 4'd0; m_dv = 1'b0; m_ill = 1'b0;
      m_hist = '0; m_cnt = 0;
    end else begin
      m_dv  = 1'b0;
      m_ill = 1'b0;
      if (m_s != BLANK_P && m_run == SC) begin
        k = classify(m_s);
        if (k >= 0 && k < 10) begin
          m_dv  = 1'b1;
          m_bcd = 4'(k);
          if (!clear) begin
            m_hist = (m_hist << 4) | HW'(k);
            if (m_cnt < ND) m_cnt++;
          end
        end else begin
          m_ill = 1'b1;
        end
      end
      if (clear) begin
        m_hist = '0;
        m_cnt  = 0;
      end
      if (leds == m_s) begin
        if (m_run <= SC) m_run++;
      end else begin
        m_run = 1;
      end
      m_s = leds;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("digit_valid", 32'(digit_valid), 32'(m_dv));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("bcd", 32'(bcd), 32'(m_bcd));
    check("history", 32'(history), 32'(m_hist));
    check("count", 32'(count), 32'(m_cnt));
    check("exclusive", 32'(digit_valid & illegal), 32'(0));
    if (digit_valid === 1'b1) begin
      dv_n++;
      dv_cyc = cyc;
    end
    if (illegal === 1'b1) ill_n++;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    leds = p;
    repeat (n) cycle();
  endtask

  initial begin
    logic [6:0] p;
    int r;
    int n;

    reset = 1'b0;
    clear = 1'b0;
    leds  = BLANK_P;
    repeat (2) cycle();
    check("reset_count", 32'(count), 32'(0));
    check("reset_history", 32'(history), 32'(0));
    reset = 1'b1;

    // Digit 3 held 6 cycles: one pulse SC edges after the first sampling edge
    dv_n = 0; ill_n = 0; start = cyc;
    hold(digit_pat[3], 6);
    check("t3_pulses", 32'(dv_n), 32'(1));
    check("t3_latency", 32'(dv_cyc - (start + 1)), 32'(SC));
    check("t3_bcd", 32'(bcd), 32'(3));
    check("t3_hist_low", 32'(history[3:0]), 32'(3));
    check("t3_count", 32'(count), 32'(1));

    // Fast 1/2 alternation never settles
    hold(BLANK_P, 2);
    dv_n = 0; ill_n = 0;
    for (int i = 0; i < 10; i++) hold((i % 2 == 1) ? digit_pat[2] : digit_pat[1], 2);
    check("alt_no_valid", 32'(dv_n), 32'(0));
    check("alt_no_illegal", 32'(ill_n), 32'(0));

    // Digits 1..5 separated by blanks; history saturates at 4 digits
    clear = 1'b1;
    hold(BLANK_P, 1);
    clear = 1'b0;
    hold(BLANK_P, 1);
    dv_n = 0;
    for (int d = 1; d <= 5; d++) begin
      hold(digit_pat[d], 5);
      hold(BLANK_P, 2);
    end
    check("seq_history", 32'(history), 32'h2345);
    check("seq_count", 32'(count), 32'(4));
    check("seq_pulses", 32'(dv_n), 32'(5));

    // Illegal stable pattern
    dv_n = 0; ill_n = 0;
    hold(7'b0101010, 5);
    check("ill_pulses", 32'(ill_n), 32'(1));
    check("ill_no_valid", 32'(dv_n), 32'(0));
    check("ill_bcd", 32'(bcd), 32'(5));
    check("ill_history", 32'(history), 32'h2345);
    check("ill_count", 32'(count), 32'(4));

    // Long hold gives one pulse; clear on the accepting edge of 9
    hold(BLANK_P, 2);
    dv_n = 0;
    hold(digit_pat[5], 10);
    check("long_pulses", 32'(dv_n), 32'(1));
    hold(BLANK_P, 2);
    leds = digit_pat[9];
    repeat (4) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clr_valid", 32'(digit_valid), 32'(1));
    check("clr_history", 32'(history), 32'(0));
    check("clr_count", 32'(count), 32'(0));
    check("clr_bcd", 32'(bcd), 32'(9));
    hold(digit_pat[9], 2);

    // Reset in the middle of filtering an 8
    hold(BLANK_P, 2);
    hold(digit_pat[8], 2);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    start = cyc; dv_n = 0;
    hold(digit_pat[8], 8);
    check("rst_pulses", 32'(dv_n), 32'(1));
    check("rst_latency", 32'(dv_cyc - (start + 1)), 32'(SC));
    check("rst_bcd", 32'(bcd), 32'(8));

    // Randomized segments against the model
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      p = digit_pat[$urandom_range(0, 9)];
      else if (r < 75) p = BLANK_P;
      else             p = 7'($urandom);
      n = $urandom_range(1, 7);
      clear = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 39) != 0);
      leds  = p;
      repeat (n) begin
        cycle();
        clear = 1'b0;
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
